// File: rtl/sub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sub_pkg                                                                    |
// | Shared state encoding and counter sizing for the serial subtractor.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-digit operation still needs a one-bit counter.
    function automatic int ctr_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sub_digit                                                                  |
// | Combinational DIGIT-bit ripple of full-subtractor cells.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    logic [DIGIT:0] w_borrow;

    assign w_borrow[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign diff[i]       = x[i] ^ y[i] ^ w_borrow[i];
        assign w_borrow[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_borrow[i]);
    end

    assign bout = w_borrow[DIGIT];

endmodule
`default_nettype wire

// File: rtl/serial_sub_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_sub_unit                                                            |
// | Multi-cycle D = A - B - BI, DIGIT bits per clock, LSB digit first.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_sub_unit
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             zero,
    output logic             ovf
);

    localparam int NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW   = ctr_width(NDIG);
    localparam logic [CW-1:0] c_last = CW'(NDIG - 1);

    if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("serial_sub_unit: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_ctr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_borrow;
    logic             r_bo;
    logic             r_zero;
    logic             r_ovf;
    logic [DIGIT-1:0] w_diff;
    logic             w_bout;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [WIDTH-1:0] w_d_next;
    logic             w_last;

    // Operands shift down so the active digit is always in the low bits.
    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (r_a[DIGIT-1:0]),
        .y    (r_b[DIGIT-1:0]),
        .bin  (r_borrow),
        .diff (w_diff),
        .bout (w_bout)
    );

    // New digits enter at the top; after NDIG steps digit 0 sits at the bottom.
    if (NDIG == 1) begin : g_single
        assign w_a_shift = r_a;
        assign w_b_shift = r_b;
        assign w_d_next  = w_diff;
    end else begin : g_multi
        assign w_a_shift = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
        assign w_b_shift = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
        assign w_d_next  = {w_diff, r_d[WIDTH-1:DIGIT]};
    end

    assign w_last = (r_ctr == c_last);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_borrow <= 1'b0;
            r_bo     <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_borrow <= bi;
                        r_ctr    <= '0;
                        r_d      <= '0;
                    end
                end
                RUN: begin
                    r_a      <= w_a_shift;
                    r_b      <= w_b_shift;
                    r_borrow <= w_bout;
                    r_d      <= w_d_next;
                    r_ctr    <= r_ctr + 1'b1;
                    if (w_last) begin
                        r_bo   <= w_bout;
                        r_zero <= (w_d_next == '0);
                        r_ovf  <= (r_a_msb != r_b_msb) && (w_diff[DIGIT-1] != r_a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign d    = r_d;
    assign bo   = r_bo;
    assign zero = r_zero;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
